dot_scan_sequencer: RTL and testbench

Parametrised successor to the dot sequencer. Holds a ROWS x COLS firing-bit matrix, a PAT_LEN-bit dot pattern and a per-line pattern-select map, all loaded through one word-wide write port. Adds an internal scan engine that walks the matrix autonomously in row-major or column-major order, with a programmable dwell per position, a start/stop/busy/done handshake and registered firing outputs. Sits between the host register interface and the motor driver output stage.

---
 rtl/dot_scan_sequencer_if.sv | 46 ++++
 rtl/dot_scan_sequencer.sv | 180 ++++++++++++++++++
 tb/tb_dot_scan_sequencer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dot_scan_sequencer_if.sv
// rtl/dot_scan_sequencer_if.sv - host/driver bundle for the dot scan sequencer (loop signal with DOT_SEQ_LOOP_EN)
interface dot_scan_sequencer_if #(
    parameter int ADDR_W  = 6,
    parameter int WSEL_W  = 3,
    parameter int WORD_W  = 16,
    parameter int DWELL_W = 8
);
    logic               wr_en;
    logic [1:0]         wr_target;
    logic [ADDR_W-1:0]  wr_addr;
    logic [WSEL_W-1:0]  wr_word_sel;
    logic [WORD_W-1:0]  wr_data;
    logic               start;
    logic               stop;
    logic               scan_order;
    logic               map_by_col;
    logic [DWELL_W-1:0] dwell;
`ifdef DOT_SEQ_LOOP_EN
    logic               loop;
`endif
    logic               busy;
    logic               done;
    logic [ADDR_W-1:0]  cur_row;
    logic [ADDR_W-1:0]  cur_col;
    logic               fire_valid;
    logic               firing_bit;
    logic               firing_data;

    modport master (
`ifdef DOT_SEQ_LOOP_EN
        output loop,
`endif
        output wr_en, wr_target, wr_addr, wr_word_sel, wr_data,
        output start, stop, scan_order, map_by_col, dwell,
        input  busy, done, cur_row, cur_col, fire_valid, firing_bit, firing_data
    );

    modport slave (
`ifdef DOT_SEQ_LOOP_EN
        input  loop,
`endif
        input  wr_en, wr_target, wr_addr, wr_word_sel, wr_data,
        input  start, stop, scan_order, map_by_col, dwell,
        output busy, done, cur_row, cur_col, fire_valid, firing_bit, firing_data
    );
endinterface

// File: rtl/dot_scan_sequencer.sv
// rtl/dot_scan_sequencer.sv - firing matrix + dot pattern store with autonomous scan engine
// Optional repeat-scan mode enabled by defining DOT_SEQ_LOOP_EN.
module dot_scan_sequencer #(
    parameter int ROWS    = 48,
    parameter int COLS    = 48,
    parameter int PAT_LEN = 48,
    parameter int WORD_W  = 16,
    parameter int ADDR_W  = 6,
    parameter int WSEL_W  = 3,
    parameter int DWELL_W = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    dot_scan_sequencer_if.slave   bus
);
    localparam int MAP_N     = (ROWS > COLS) ? ROWS : COLS;
    localparam int COL_WORDS = COLS / WORD_W;
    localparam int PAT_WORDS = PAT_LEN / WORD_W;

    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL  = ADDR_W'(COLS - 1);
    localparam logic [ADDR_W:0]   ROW_LIM   = (ADDR_W+1)'(ROWS);
    localparam logic [ADDR_W:0]   MAP_LIM   = (ADDR_W+1)'(MAP_N);
    localparam logic [ADDR_W:0]   PAT_LIM   = (ADDR_W+1)'(PAT_LEN);
    localparam logic [WSEL_W:0]   CW_LIM    = (WSEL_W+1)'(COL_WORDS);
    localparam logic [WSEL_W:0]   PW_LIM    = (WSEL_W+1)'(PAT_WORDS);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    logic [COLS-1:0]    matrix  [ROWS];
    logic [PAT_LEN-1:0] pattern;
    logic [ADDR_W-1:0]  sel_map [MAP_N];

    state_t             state, state_nx;
    logic [ADDR_W-1:0]  row_q, col_q, row_nx, col_nx;
    logic [DWELL_W-1:0] cnt_q, cnt_nx, dwell_q;
    logic               order_q, by_col_q, loop_q;
    logic               latch_cfg;
    logic               last_pos;

    logic               fire_valid_q, firing_bit_q, firing_data_q;
    logic [ADDR_W-1:0]  map_idx, map_val;
    logic               pat_bit;
    logic               emit;

    // Storage has no reset; out-of-range rows, map slots and word selects are dropped.
    always_ff @(posedge clock) begin
        if (bus.wr_en) begin
            case (bus.wr_target)
                2'd0: if (({1'b0, bus.wr_addr} < ROW_LIM) && ({1'b0, bus.wr_word_sel} < CW_LIM))
                          matrix[bus.wr_addr][bus.wr_word_sel*WORD_W +: WORD_W] <= bus.wr_data;
                2'd1: if ({1'b0, bus.wr_word_sel} < PW_LIM)
                          pattern[bus.wr_word_sel*WORD_W +: WORD_W] <= bus.wr_data;
                2'd2: if ({1'b0, bus.wr_addr} < MAP_LIM)
                          sel_map[bus.wr_addr] <= bus.wr_data[ADDR_W-1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            row_q    <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            dwell_q  <= '0;
            order_q  <= 1'b0;
            by_col_q <= 1'b0;
        end else begin
            state <= state_nx;
            row_q <= row_nx;
            col_q <= col_nx;
            cnt_q <= cnt_nx;
            if (latch_cfg) begin
                dwell_q  <= bus.dwell;
                order_q  <= bus.scan_order;
                by_col_q <= bus.map_by_col;
            end
        end
    end

`ifdef DOT_SEQ_LOOP_EN
    always_ff @(posedge clock) begin
        if (reset)          loop_q <= 1'b0;
        else if (latch_cfg) loop_q <= bus.loop;
    end
`else
    assign loop_q = 1'b0;
`endif

    assign last_pos = (row_q == LAST_ROW) && (col_q == LAST_COL);

    always_comb begin
        state_nx  = state;
        row_nx    = row_q;
        col_nx    = col_q;
        cnt_nx    = cnt_q;
        latch_cfg = 1'b0;
        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nx  = RUN;
                    row_nx    = '0;
                    col_nx    = '0;
                    cnt_nx    = '0;
                    latch_cfg = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == dwell_q) begin
                    cnt_nx = '0;
                    if (last_pos) begin
                        if (loop_q) begin
                            row_nx = '0;
                            col_nx = '0;
                        end else begin
                            state_nx = DONE;
                        end
                    end else if (!order_q) begin
                        if (col_q == LAST_COL) begin
                            col_nx = '0;
                            row_nx = row_q + ADDR_W'(1);
                        end else begin
                            col_nx = col_q + ADDR_W'(1);
                        end
                    end else begin
                        if (row_q == LAST_ROW) begin
                            row_nx = '0;
                            col_nx = col_q + ADDR_W'(1);
                        end else begin
                            row_nx = row_q + ADDR_W'(1);
                        end
                    end
                end else begin
                    cnt_nx = cnt_q + DWELL_W'(1);
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        // Abort freezes the position so the host can see where the scan stopped.
        if (bus.stop) begin
            state_nx  = IDLE;
            row_nx    = row_q;
            col_nx    = col_q;
            cnt_nx    = cnt_q;
            latch_cfg = 1'b0;
        end
    end

    always_comb begin
        map_idx = by_col_q ? col_q : row_q;
        map_val = sel_map[map_idx];
        pat_bit = 1'b0;
        if ({1'b0, map_val} < PAT_LIM) pat_bit = pattern[map_val];
    end

    assign emit = (state == RUN) && !bus.stop;

    always_ff @(posedge clock) begin
        if (reset) begin
            fire_valid_q  <= 1'b0;
            firing_bit_q  <= 1'b0;
            firing_data_q <= 1'b0;
        end else begin
            fire_valid_q  <= emit;
            firing_bit_q  <= emit ? matrix[row_q][col_q] : 1'b0;
            firing_data_q <= emit ? pat_bit : 1'b0;
        end
    end

    assign bus.busy        = (state == RUN);
    assign bus.done        = (state == DONE);
    assign bus.cur_row     = row_q;
    assign bus.cur_col     = col_q;
    assign bus.fire_valid  = fire_valid_q;
    assign bus.firing_bit  = firing_bit_q;
    assign bus.firing_data = firing_data_q;
endmodule

// File: tb/tb_dot_scan_sequencer.sv
// tb/tb_dot_scan_sequencer.sv - scoreboard bench for dot_scan_sequencer
module tb_dot_scan_sequencer;
    localparam int ROWS = 48, COLS = 48, PAT_LEN = 48, WORD_W = 16;
    localparam int ADDR_W = 6, WSEL_W = 3, DWELL_W = 8;
    localparam int MAP_N = 48;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    dot_scan_sequencer_if #(.ADDR_W(ADDR_W), .WSEL_W(WSEL_W), .WORD_W(WORD_W), .DWELL_W(DWELL_W)) bus();

    dot_scan_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .PAT_LEN(PAT_LEN), .WORD_W(WORD_W),
        .ADDR_W(ADDR_W), .WSEL_W(WSEL_W), .DWELL_W(DWELL_W)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus)
    );

    typedef struct {int r; int c; int b; int d;} exp_t;
    exp_t exp_q[$];

    bit mat [ROWS][COLS];
    bit pat [PAT_LEN];
    int map_mem [MAP_N];

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int prev_row = 0;
    int prev_col = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: each valid firing output must match the next model entry for the prior cycle's position.
    always @(negedge clock) begin
        if (!reset && bus.fire_valid) begin
            if (exp_q.size() == 0) begin
                chk("fire_unexpected", 1, 0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("fire_row", prev_row, e.r);
                chk("fire_col", prev_col, e.c);
                chk("firing_bit", bus.firing_bit, e.b);
                chk("firing_data", bus.firing_data, e.d);
            end
        end
        if (!reset && bus.done) done_cnt++;
        prev_row = bus.cur_row;
        prev_col = bus.cur_col;
    end

    task automatic wr(input int tgt, input int addr, input int ws, input int data);
        bus.wr_en       = 1'b1;
        bus.wr_target   = tgt[1:0];
        bus.wr_addr     = addr[ADDR_W-1:0];
        bus.wr_word_sel = ws[WSEL_W-1:0];
        bus.wr_data     = data[WORD_W-1:0];
        @(negedge clock);
        bus.wr_en = 1'b0;
        if (tgt == 0 && addr < ROWS && ws < COLS / WORD_W)
            for (int b = 0; b < WORD_W; b++) mat[addr][ws*WORD_W + b] = data[b];
        else if (tgt == 1 && ws < PAT_LEN / WORD_W)
            for (int b = 0; b < WORD_W; b++) pat[ws*WORD_W + b] = data[b];
        else if (tgt == 2 && addr < MAP_N)
            map_mem[addr] = data % (1 << ADDR_W);
    endtask

    task automatic fill_random();
        for (int r = 0; r < ROWS; r++)
            for (int w = 0; w < COLS / WORD_W; w++) wr(0, r, w, int'($urandom_range(0, 65535)));
        for (int w = 0; w < PAT_LEN / WORD_W; w++) wr(1, 0, w, int'($urandom_range(0, 65535)));
        for (int m = 0; m < MAP_N; m++) wr(2, m, 0, int'($urandom_range(0, 63)));
    endtask

    // Reference: the k-th visited position, each held dw+1 cycles.
    task automatic push_scan(input bit ord, input bit bc, input int dw, input int n);
        int k, r, c, idx, d;
        for (int p = 0; p < n; p++) begin
            k = p % (ROWS * COLS);
            r = ord ? k % ROWS : k / COLS;
            c = ord ? k / ROWS : k % COLS;
            idx = bc ? c : r;
            d = (map_mem[idx] < PAT_LEN) ? int'(pat[map_mem[idx]]) : 0;
            for (int h = 0; h <= dw; h++) exp_q.push_back('{r, c, int'(mat[r][c]), d});
        end
    endtask

    task automatic configure(input bit ord, input bit bc, input int dw, input bit lp);
        bus.scan_order = ord;
        bus.map_by_col = bc;
        bus.dwell      = dw[DWELL_W-1:0];
`ifdef DOT_SEQ_LOOP_EN
        bus.loop       = lp;
`else
        if (lp) $display("loop request ignored without loop support");
`endif
    endtask

    task automatic run_scan(input bit ord, input bit bc, input int dw);
        int busy_n, n, d0;
        configure(ord, bc, dw, 1'b0);
        push_scan(ord, bc, dw, ROWS * COLS);
        d0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        busy_n = 0;
        n = 0;
        while (!bus.done && n < ROWS * COLS * (dw + 1) + 50) begin
            if (bus.busy) busy_n++;
            @(negedge clock);
            n++;
        end
        chk("done_reached", bus.done, 1);
        chk("busy_cycles", busy_n, ROWS * COLS * (dw + 1));
        chk("busy_at_done", bus.busy, 0);
        chk("final_row", bus.cur_row, ROWS - 1);
        chk("final_col", bus.cur_col, COLS - 1);
        @(negedge clock);
        chk("done_width", bus.done, 0);
        chk("idle_busy", bus.busy, 0);
        chk("idle_fire_valid", bus.fire_valid, 0);
        chk("idle_cur_row", bus.cur_row, ROWS - 1);
        chk("done_pulses", done_cnt - d0, 1);
        chk("scoreboard_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n, d0;
        bus.wr_en = 1'b0; bus.wr_target = '0; bus.wr_addr = '0; bus.wr_word_sel = '0;
        bus.wr_data = '0; bus.start = 1'b1; bus.stop = 1'b0; bus.scan_order = 1'b0;
        bus.map_by_col = 1'b0; bus.dwell = '0;
`ifdef DOT_SEQ_LOOP_EN
        bus.loop = 1'b0;
`endif
        // Reset held with start asserted.
        repeat (4) begin
            @(negedge clock);
            chk("rst_busy", bus.busy, 0);
            chk("rst_done", bus.done, 0);
            chk("rst_fire_valid", bus.fire_valid, 0);
            chk("rst_cur", {bus.cur_row, bus.cur_col}, 0);
        end
        reset = 1'b0;
        bus.start = 1'b0;
        repeat (3) begin
            @(negedge clock);
            chk("post_rst_idle", bus.busy, 0);
        end

        fill_random();
        // Dropped writes: bad row, bad word select, bad pattern word, bad map slot, ignored target.
        wr(0, 50, 0, 16'hFFFF);
        wr(0, 3, 5, 16'hFFFF);
        wr(1, 0, 4, 16'hFFFF);
        wr(2, 55, 0, 7);
        wr(3, 1, 1, 16'hFFFF);

        // Directed: row 2 = ...101, map[0..2]=3, pattern bit 3 set.
        wr(0, 2, 0, 16'h0005);
        wr(2, 0, 0, 3);
        wr(2, 1, 0, 3);
        wr(2, 2, 0, 3);
        wr(1, 0, 0, 16'h0008);
        run_scan(1'b0, 1'b1, 1);

        run_scan(1'b0, 1'b0, 0);
        run_scan(1'b1, 1'($urandom_range(0, 1)), 2);

        fill_random();
        run_scan(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), int'($urandom_range(0, 1)));

        // Abort at (5,7) with start in the same cycle.
        configure(1'b0, 1'b1, 0, 1'b0);
        push_scan(1'b0, 1'b1, 0, 5 * COLS + 7);
        d0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.cur_row == 5 && bus.cur_col == 7) && n < 1000) begin
            @(negedge clock);
            n++;
        end
        chk("stop_pos_reached", (bus.cur_row == 5 && bus.cur_col == 7), 1);
        bus.stop = 1'b1;
        bus.start = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        bus.start = 1'b0;
        chk("stop_busy", bus.busy, 0);
        chk("stop_fire_valid", bus.fire_valid, 0);
        chk("stop_done", bus.done, 0);
        chk("stop_cur_row", bus.cur_row, 5);
        chk("stop_cur_col", bus.cur_col, 7);
        chk("stop_scoreboard", exp_q.size(), 0);
        @(negedge clock);
        chk("stop_still_idle", bus.busy, 0);
        chk("stop_no_done", done_cnt - d0, 0);
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        chk("restart_busy", bus.busy, 1);
        chk("restart_cur", {bus.cur_row, bus.cur_col}, 0);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        chk("restart_abort", bus.busy, 0);
        exp_q.delete();

`ifdef DOT_SEQ_LOOP_EN
        wr(2, 0, 0, 50);
        configure(1'b0, 1'b1, 0, 1'b1);
        push_scan(1'b0, 1'b1, 0, ROWS * COLS + 9);
        d0 = done_cnt;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        n = 0;
        while (!(bus.cur_row == ROWS - 1 && bus.cur_col == COLS - 1) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        chk("loop_last_reached", (bus.cur_row == ROWS - 1 && bus.cur_col == COLS - 1), 1);
        @(negedge clock);
        chk("loop_wrap_cur", {bus.cur_row, bus.cur_col}, 0);
        chk("loop_wrap_busy", bus.busy, 1);
        chk("loop_wrap_done", bus.done, 0);
        repeat (9) @(negedge clock);
        bus.stop = 1'b1;
        @(negedge clock);
        bus.stop = 1'b0;
        chk("loop_stop_busy", bus.busy, 0);
        @(negedge clock);
        chk("loop_no_done", done_cnt - d0, 0);
        chk("loop_scoreboard", exp_q.size(), 0);
        exp_q.delete();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
